// File: rtl/id_stage_ctrl.sv
// IF/ID stage controller: ID register, immediate-format decode, load-use
// hazard detection with fetch stall / EX bubble, and squash on EX redirect.
// Optional macro ID_PERF_EN adds saturating stall and redirect counters.
module id_stage_ctrl #(
  parameter logic [31:0] NOP_INST  = 32'h00000013,
  parameter int unsigned FLUSH_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  input  logic [31:0] if_inst,
  input  logic [31:0] if_pc,
  input  logic        ex_valid,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rd,
  input  logic        ex_redirect,
  output logic        stall_if,
  output logic        id_bubble,
  output logic        id_valid,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic [2:0]  imm_type
`ifdef ID_PERF_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt_o
`endif
);

  typedef enum logic [1:0] {StRun, StStall, StFlush} state_e;

  localparam logic [2:0] ImmNone = 3'b000;
  localparam logic [2:0] ImmI    = 3'b001;
  localparam logic [2:0] ImmB    = 3'b010;
  localparam logic [2:0] ImmS    = 3'b011;
  localparam logic [2:0] ImmJ    = 3'b100;
  localparam logic [2:0] ImmU    = 3'b101;

  localparam logic [2:0] FlushInit = 3'(FLUSH_LAT - 1);

  function automatic logic [2:0] decode_imm(input logic [6:0] op);
    logic [2:0] t;
    unique case (op)
      7'b0010011, 7'b0000011, 7'b1100111: t = ImmI;
      7'b1100011:                         t = ImmB;
      7'b0100011:                         t = ImmS;
      7'b1101111:                         t = ImmJ;
      7'b0110111, 7'b0010111:             t = ImmU;
      default:                            t = ImmNone;
    endcase
    return t;
  endfunction

  state_e      state_q, state_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_inst_q, id_inst_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [2:0]  imm_type_q, imm_type_d;
  logic [2:0]  flush_cnt_q, flush_cnt_d;

  logic [6:0] id_op;
  logic       rs1_used, rs2_used, hazard;

  // Load-use hazard between the load in EX and the source registers of ID.
  always_comb begin
    id_op    = id_inst_q[6:0];
    // J and U formats carry immediate bits where rs1 would be.
    rs1_used = !((id_op == 7'b1101111) || (id_op == 7'b0110111) || (id_op == 7'b0010111));
    rs2_used = (id_op == 7'b1100011) || (id_op == 7'b0100011) || (id_op == 7'b0110011);
    hazard   = id_valid_q && ex_valid && ex_mem_read && (ex_rd != 5'd0) &&
               ((rs1_used && (ex_rd == id_inst_q[19:15])) ||
                (rs2_used && (ex_rd == id_inst_q[24:20])));
    // A redirect squashes ID anyway, so it overrides the stall.
    stall_if  = hazard && !ex_redirect && (state_q != StFlush);
    id_bubble = stall_if;
  end

  // Next-state for the FSM and the ID register contents.
  always_comb begin
    state_d     = state_q;
    id_valid_d  = id_valid_q;
    id_inst_d   = id_inst_q;
    id_pc_d     = id_pc_q;
    imm_type_d  = imm_type_q;
    flush_cnt_d = flush_cnt_q;
    if (ex_redirect) begin
      id_valid_d  = 1'b0;
      id_inst_d   = NOP_INST;
      imm_type_d  = decode_imm(NOP_INST[6:0]);
      flush_cnt_d = FlushInit;
      state_d     = (FLUSH_LAT > 1) ? StFlush : StRun;
    end else begin
      unique case (state_q)
        StRun, StStall: begin
          if (hazard) begin
            state_d = StStall;
          end else begin
            state_d = StRun;
            if (if_valid) begin
              id_valid_d = 1'b1;
              id_inst_d  = if_inst;
              id_pc_d    = if_pc;
              imm_type_d = decode_imm(if_inst[6:0]);
            end else begin
              id_valid_d = 1'b0;
            end
          end
        end
        StFlush: begin
          id_valid_d  = 1'b0;
          flush_cnt_d = flush_cnt_q - 3'd1;
          if (flush_cnt_q <= 3'd1) begin
            flush_cnt_d = 3'd0;
            state_d     = StRun;
          end
        end
        default: state_d = StRun;
      endcase
    end
  end

  // State and ID register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StRun;
      id_valid_q  <= 1'b0;
      id_inst_q   <= NOP_INST;
      id_pc_q     <= 32'd0;
      imm_type_q  <= ImmI;
      flush_cnt_q <= 3'd0;
    end else begin
      state_q     <= state_d;
      id_valid_q  <= id_valid_d;
      id_inst_q   <= id_inst_d;
      id_pc_q     <= id_pc_d;
      imm_type_q  <= imm_type_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign id_valid = id_valid_q;
  assign id_inst  = id_inst_q;
  assign id_pc    = id_pc_q;
  assign imm_type = imm_type_q;

`ifdef ID_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] redirect_cnt_q;

  // Saturating event counters for stall cycles and accepted redirects.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q    <= 32'd0;
      redirect_cnt_q <= 32'd0;
    end else begin
      if (stall_if && (stall_cnt_q != 32'hFFFFFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (ex_redirect && (redirect_cnt_q != 32'hFFFFFFFF)) begin
        redirect_cnt_q <= redirect_cnt_q + 32'd1;
      end
    end
  end

  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt_o = redirect_cnt_q;
`endif

endmodule
